// File: rtl/sha_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha_stream_pkg                                                      |
// | Shared types and constants for the SHA-256 digest streamer.         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package sha_stream_pkg;

  localparam int DIGEST_WORDS = 8;
  localparam int WORD_W       = 32;

  localparam logic [31:0] DEFAULT_MAILBOX_ADDR = 32'h0000_1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/digest_snapshot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | digest_snapshot                                                     |
// | 8x32 digest register bank with word-select read mux; the optional   |
// | XOR checksum word is built only under DIGEST_STREAMER_CHECKSUM_EN.  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module digest_snapshot
  import sha_stream_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load,
  input  logic [DIGEST_WORDS*WORD_W-1:0] digest_in,
  input  logic [3:0]                     sel,
  output logic [WORD_W-1:0]              word_out
);

  logic [WORD_W-1:0] r_bank [DIGEST_WORDS];

  // Word 0 is the most significant slice of the digest vector (x10).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGEST_WORDS; i++) r_bank[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < DIGEST_WORDS; i++)
        r_bank[i] <= digest_in[(DIGEST_WORDS-1-i)*WORD_W +: WORD_W];
    end
  end

`ifdef DIGEST_STREAMER_CHECKSUM_EN
  logic [WORD_W-1:0] w_checksum;

  always_comb begin
    w_checksum = '0;
    for (int i = 0; i < DIGEST_WORDS; i++) w_checksum = w_checksum ^ r_bank[i];
  end
`endif

  always_comb begin
    word_out = '0;
    if (sel < 4'(DIGEST_WORDS))
      word_out = r_bank[sel[2:0]];
`ifdef DIGEST_STREAMER_CHECKSUM_EN
    else if (sel == 4'(DIGEST_WORDS))
      word_out = w_checksum;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/sha256_digest_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sha256_digest_streamer                                              |
// | Snoops a mailbox store, snapshots the register-file digest and      |
// | streams it as 32-bit words over valid/ready.                        |
// | Option: DIGEST_STREAMER_CHECKSUM_EN appends an XOR checksum word.   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sha256_digest_streamer
  import sha_stream_pkg::*;
#(
  parameter logic [31:0] MAILBOX_ADDR = DEFAULT_MAILBOX_ADDR
)(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DIGEST_WORDS*WORD_W-1:0] digest_in,
  input  logic [31:0]                    bus_addr,
  input  logic [31:0]                    bus_din,
  input  logic [3:0]                     bus_we,
  output logic [WORD_W-1:0]              out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           overrun
);

`ifdef DIGEST_STREAMER_CHECKSUM_EN
  localparam logic [3:0] C_LAST_IDX = 4'(DIGEST_WORDS);
`else
  localparam logic [3:0] C_LAST_IDX = 4'(DIGEST_WORDS - 1);
`endif

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_trig_pend;
  logic       r_valid;
  logic       r_last;
  logic       r_overrun;

  logic w_trigger;
  logic w_accept;
  logic w_hs;
  logic w_unused_din;

  assign w_trigger    = (bus_we == 4'hF) && (bus_addr == MAILBOX_ADDR) && bus_din[0];
  // A trigger already latched but not yet in ARM counts as busy for overrun.
  assign w_accept     = (r_state == IDLE) && !r_trig_pend;
  assign w_hs         = r_valid && out_ready;
  assign w_unused_din = ^bus_din[31:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_trig_pend <= 1'b0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_trig_pend <= w_trigger && w_accept;
      if (w_trigger && !w_accept) r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_trig_pend) r_state <= ARM;
        end
        ARM: begin
          r_cnt   <= '0;
          r_valid <= 1'b1;
          r_last  <= 1'b0;
          r_state <= STREAM;
        end
        STREAM: begin
          if (w_hs) begin
            if (r_cnt == C_LAST_IDX) begin
              r_cnt   <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt  <= r_cnt + 4'd1;
              r_last <= ((r_cnt + 4'd1) == C_LAST_IDX);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  digest_snapshot u_snapshot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (r_state == ARM),
    .digest_in (digest_in),
    .sel       (r_cnt),
    .word_out  (out_data)
  );

  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign busy      = (r_state != IDLE);
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sha256_digest_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sha256_digest_streamer                                           |
// | Scoreboard bench for the digest streamer.                           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_sha256_digest_streamer;

  localparam logic [31:0] MBOX = 32'h0000_1000;
`ifdef DIGEST_STREAMER_CHECKSUM_EN
  localparam int NW = 9;
`else
  localparam int NW = 8;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] digest_in;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_din;
  logic [3:0]   bus_we;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         overrun;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  localparam logic [255:0] ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

  always #5 clk = ~clk;

  sha256_digest_streamer #(.MAILBOX_ADDR(MBOX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digest_in (digest_in),
    .bus_addr  (bus_addr),
    .bus_din   (bus_din),
    .bus_we    (bus_we),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  task automatic push_digest(input logic [255:0] d);
    logic [31:0] w;
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < 8; i++) begin
      w = d[(7-i)*32 +: 32];
      exp_q.push_back(w);
      x = x ^ w;
    end
`ifdef DIGEST_STREAMER_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic fire(input logic [31:0] addr, input logic [31:0] din, input logic [3:0] we);
    @(negedge clk);
    bus_addr = addr;
    bus_din  = din;
    bus_we   = we;
    @(posedge clk);
    #1;
    bus_addr = '0;
    bus_din  = '0;
    bus_we   = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // trig_mask bit0: trigger after 3 handshakes; bit1: trigger on final-handshake edge.
  task automatic collect(input int stall_word, input int stall_len, input int trig_mask,
                         input int abort_hs, input bit scramble,
                         output int first_cyc, output int end_cyc);
    int cyc;
    int hs;
    int stall_left;
    bit pending;
    bit trig_done;
    bit aborted;
    cyc = 0; hs = 0; stall_left = stall_len; pending = 0; trig_done = 0; aborted = 0;
    first_cyc = -1; end_cyc = -1;
    while (exp_q.size() > 0 && cyc < 60) begin
      @(negedge clk);
      bus_we = '0;
      if (hs == abort_hs) begin
        out_ready = 1'b0;
        aborted = 1;
        break;
      end
      if (pending) begin
        n_checks++;
        if (out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL valid_drop: out_valid=%b required 1 during stall", out_valid);
        end
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (scramble) digest_in = ~digest_in;
        n_checks++;
        if (out_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL word%0d: out_data=%h required %h", hs, out_data, exp_q[0]);
        end
        n_checks++;
        if (out_last !== (exp_q.size() == 1)) begin
          n_fail++;
          $display("FAIL last%0d: out_last=%b required %b", hs, out_last, exp_q.size() == 1);
        end
        if (hs == stall_word && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          pending = 1;
        end else begin
          out_ready = 1'b1;
          pending = 0;
          if (trig_mask[1] && exp_q.size() == 1) begin
            bus_addr = MBOX; bus_din = 32'h1; bus_we = 4'hF;
          end
          void'(exp_q.pop_front());
          hs++;
          if (exp_q.size() == 0) end_cyc = cyc;
        end
      end else begin
        out_ready = 1'b1;
      end
      if (trig_mask[0] && hs == 3 && !trig_done) begin
        bus_addr = MBOX; bus_din = 32'h1; bus_we = 4'hF;
        trig_done = 1;
      end
      cyc++;
    end
    if (!aborted) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL timeout: %0d words outstanding required 0", exp_q.size());
      end
      exp_q.delete();
      @(negedge clk);
      bus_we = '0;
      n_checks++;
      if ({out_valid, busy, out_last} !== 3'b000) begin
        n_fail++;
        $display("FAIL stream_end: valid/busy/last=%b required 000", {out_valid, busy, out_last});
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: %h required 0", out_data); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: %b required 0", out_valid); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_last: %b required 0", out_last); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: %b required 0", busy); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: %b required 0", overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int fc, ec;
    digest_in = ABC;
    push_digest(ABC);
    fire(MBOX, 32'h1, 4'hF);
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++; $display("FAIL lat_k: busy/valid=%b required 00", {busy, out_valid});
    end
    @(negedge clk);
    n_checks++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++; $display("FAIL lat_arm: busy/valid=%b required 10", {busy, out_valid});
    end
    collect(-1, 0, 0, -1, 0, fc, ec);
    n_checks++;
    if (fc !== 0) begin n_fail++; $display("FAIL first_valid: cycle %0d required 0", fc); end
    n_checks++;
    if (ec !== NW - 1) begin n_fail++; $display("FAIL burst_len: last at %0d required %0d", ec, NW - 1); end
  endtask

  task automatic test_backpressure();
    int fc, ec;
    digest_in = ABC;
    push_digest(ABC);
    fire(MBOX, 32'h1, 4'hF);
    collect(2, 3, 0, -1, 0, fc, ec);
    n_checks++;
    if (ec - fc !== NW - 1 + 3) begin
      n_fail++; $display("FAIL bp_len: span %0d required %0d", ec - fc, NW + 2);
    end
  endtask

  task automatic test_nontrig();
    logic [31:0] addrs [3];
    logic [31:0] dins [3];
    logic [3:0]  wes [3];
    addrs = '{MBOX, MBOX + 32'd4, MBOX};
    dins  = '{32'h1, 32'h1, 32'h2};
    wes   = '{4'h1, 4'hF, 4'hF};
    for (int i = 0; i < 3; i++) begin
      fire(addrs[i], dins[i], wes[i]);
      repeat (3) begin
        @(negedge clk);
        n_checks++;
        if ({busy, out_valid} !== 2'b00) begin
          n_fail++; $display("FAIL nontrig%0d: busy/valid=%b required 00", i, {busy, out_valid});
        end
      end
    end
  endtask

  task automatic test_isolation();
    int fc, ec;
    digest_in = ABC;
    push_digest(ABC);
    fire(MBOX, 32'h1, 4'hF);
    collect(-1, 0, 0, -1, 1, fc, ec);
    digest_in = ABC;
  endtask

  task automatic test_overrun();
    int fc, ec;
    bit seen;
    for (int m = 1; m <= 2; m++) begin
      pulse_reset();
      digest_in = ABC;
      push_digest(ABC);
      fire(MBOX, 32'h1, 4'hF);
      collect(-1, 0, m, -1, 0, fc, ec);
      n_checks++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_m%0d: %b required 1", m, overrun); end
      seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (out_valid || busy) seen = 1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL second_stream_m%0d: seen=%b required 0", m, seen); end
    end
  endtask

  task automatic test_reset_mid();
    int fc, ec;
    digest_in = ABC;
    push_digest(ABC);
    fire(MBOX, 32'h1, 4'hF);
    collect(-1, 0, 1, 5, 0, fc, ec);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, busy, overrun, out_last} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid: valid/busy/overrun/last=%b required 0000", {out_valid, busy, overrun, out_last});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    push_digest(ABC);
    fire(MBOX, 32'h1, 4'hF);
    collect(-1, 0, 0, -1, 0, fc, ec);
  endtask

  task automatic test_checksum();
    logic [255:0] d;
    int fc, ec;
    d = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    digest_in = d;
    push_digest(d);
`ifdef DIGEST_STREAMER_CHECKSUM_EN
    n_checks++;
    if (exp_q[8] !== 32'h0000_0008) begin
      n_fail++; $display("FAIL cks_model: %h required 00000008", exp_q[8]);
    end
`endif
    fire(MBOX, 32'h1, 4'hF);
    collect(-1, 0, 0, -1, 0, fc, ec);
  endtask

  initial begin
    rst_n     = 1'b0;
    digest_in = '0;
    bus_addr  = '0;
    bus_din   = '0;
    bus_we    = '0;
    out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_nontrig();
    test_isolation();
    test_overrun();
    pulse_reset();
    test_reset_mid();
    test_checksum();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
